// File: rtl/cl_capture_sequencer_if.sv
// Camera Link channel bus between the deserialiser, the capture sequencer and the pixel FIFO write port.
// The master side drives the camera bits and FIFO status; the slave (sequencer) drives FIFO writes and framing pulses.
interface cl_capture_sequencer_if #(
  parameter int DW = 24
);
  logic          fval;
  logic          lval;
  logic          dval;
  logic [DW-1:0] pix_in;
  logic          fifo_prog_full;
  logic          wr_en;
  logic [DW-1:0] pix_out;
  logic          sof;
  logic          eol;
  logic          eof;

  modport master (
    output fval, lval, dval, pix_in, fifo_prog_full,
    input  wr_en, pix_out, sof, eol, eof
  );

  modport slave (
    input  fval, lval, dval, pix_in, fifo_prog_full,
    output wr_en, pix_out, sof, eol, eof
  );
endinterface

// File: rtl/cl_capture_sequencer.sv
// Frame-capture controller for one Camera Link channel: aligns to a whole frame, gates FIFO writes,
// counts pixels/lines/frames and keeps sticky line-length, frame-height and overflow error flags.
module cl_capture_sequencer #(
  parameter int PIX_PER_BEAT = 2,
  parameter int DW           = 24,
  parameter int CNT_W        = 16
) (
  input  logic                  rxclk_div_1,
  input  logic                  sys_rst,
  input  logic                  locked_i,
  input  logic                  arm_i,
  input  logic                  clr_err_i,
  input  logic [CNT_W-1:0]      line_width_i,
  input  logic [CNT_W-1:0]      frame_height_i,
  cl_capture_sequencer_if.slave cl,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      frame_count_o,
  output logic                  err_line_len_o,
  output logic                  err_frame_h_o,
  output logic                  err_overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT_SOF,
    S_ACTIVE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Input stage plus one cycle of edge history
  logic          fval_q, lval_q, dval_q;
  logic [DW-1:0] pix_q;
  logic          fval_dly_q, lval_dly_q;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic             ovf_blk_q, ovf_blk_d;
  logic             err_line_q, err_line_d;
  logic             err_fh_q, err_fh_d;
  logic             err_ovf_q, err_ovf_d;

  logic          wr_q, wr_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic [DW-1:0] pix_out_q;

  logic             in_frame;
  logic [CNT_W:0]   pix_sum;
  logic             beat, fval_rise, frame_end, line_end;

  assign beat      = fval_q & lval_q & dval_q;
  assign fval_rise = fval_q & ~fval_dly_q;
  assign frame_end = ~fval_q & fval_dly_q;
  // A line only counts if it ended while the frame was still open
  assign line_end  = ~lval_q & lval_dly_q & fval_dly_q;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    fc_d       = fc_q;
    ovf_blk_d  = ovf_blk_q;
    err_line_d = err_line_q & ~clr_err_i;
    err_fh_d   = err_fh_q & ~clr_err_i;
    err_ovf_d  = err_ovf_q & ~clr_err_i;
    wr_d       = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    in_frame   = 1'b0;
    pix_sum    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (arm_i && locked_i) begin
          state_d    = S_SYNC;
          fc_d       = '0;
          err_line_d = 1'b0;
          err_fh_d   = 1'b0;
          err_ovf_d  = 1'b0;
        end
      end
      S_SYNC: begin
        if (!fval_q) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (fval_rise) begin
          state_d    = S_ACTIVE;
          sof_d      = 1'b1;
          in_frame   = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          ovf_blk_d  = 1'b0;
        end
      end
      S_ACTIVE: in_frame = 1'b1;
      S_DONE:   state_d  = arm_i ? S_WAIT_SOF : S_IDLE;
      default:  state_d  = S_IDLE;
    endcase

    if (in_frame) begin
      if (beat) begin
        // The beat that first sees prog_full is dropped too; the FIFO has no room for it
        wr_d = ~ovf_blk_d & ~cl.fifo_prog_full;
        if (cl.fifo_prog_full) begin
          ovf_blk_d = 1'b1;
          err_ovf_d = 1'b1;
        end
        pix_sum   = {1'b0, pix_cnt_d} + (CNT_W+1)'(PIX_PER_BEAT);
        pix_cnt_d = pix_sum[CNT_W] ? '1 : pix_sum[CNT_W-1:0];
      end
      if (line_end) begin
        eol_d = 1'b1;
        if (pix_cnt_d != line_width_i) err_line_d = 1'b1;
        line_cnt_d = line_cnt_d + CNT_W'(1);
        pix_cnt_d  = '0;
      end
      // Ordered after the line update so a shared falling edge checks the final line count
      if (frame_end) begin
        eof_d     = 1'b1;
        fc_d      = fc_q + CNT_W'(1);
        state_d   = S_DONE;
        ovf_blk_d = 1'b0;
        if (line_cnt_d != frame_height_i) err_fh_d = 1'b1;
      end
    end

    if (!locked_i) begin
      state_d    = S_IDLE;
      wr_d       = 1'b0;
      sof_d      = 1'b0;
      eol_d      = 1'b0;
      eof_d      = 1'b0;
      fc_d       = fc_q;
      ovf_blk_d  = 1'b0;
      pix_cnt_d  = pix_cnt_q;
      line_cnt_d = line_cnt_q;
      err_line_d = err_line_q & ~clr_err_i;
      err_fh_d   = err_fh_q & ~clr_err_i;
      err_ovf_d  = err_ovf_q & ~clr_err_i;
    end
  end

  always_ff @(posedge rxclk_div_1 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      dval_q     <= 1'b0;
      pix_q      <= '0;
      fval_dly_q <= 1'b0;
      lval_dly_q <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      fc_q       <= '0;
      ovf_blk_q  <= 1'b0;
      err_line_q <= 1'b0;
      err_fh_q   <= 1'b0;
      err_ovf_q  <= 1'b0;
      wr_q       <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      pix_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      fval_q     <= cl.fval;
      lval_q     <= cl.lval;
      dval_q     <= cl.dval;
      pix_q      <= cl.pix_in;
      fval_dly_q <= fval_q;
      lval_dly_q <= lval_q;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      fc_q       <= fc_d;
      ovf_blk_q  <= ovf_blk_d;
      err_line_q <= err_line_d;
      err_fh_q   <= err_fh_d;
      err_ovf_q  <= err_ovf_d;
      wr_q       <= wr_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      if (wr_d) pix_out_q <= pix_q;
    end
  end

  assign cl.wr_en        = wr_q;
  assign cl.pix_out      = pix_out_q;
  assign cl.sof          = sof_q;
  assign cl.eol          = eol_q;
  assign cl.eof          = eof_q;
  assign busy_o          = (state_q == S_WAIT_SOF) || (state_q == S_ACTIVE);
  assign frame_count_o   = fc_q;
  assign err_line_len_o  = err_line_q;
  assign err_frame_h_o   = err_fh_q;
  assign err_overflow_o  = err_ovf_q;

endmodule

// File: tb/tb_cl_capture_sequencer.sv
// Randomised frame stimulus for cl_capture_sequencer, checked per frame against a line-level model
// of what should be written, which pulses should appear and which sticky flags should be set.
module tb_cl_capture_sequencer;
  localparam int DW = 24, CNT_W = 16, PPB = 2;

  logic             rxclk_div_1 = 1'b0;
  logic             sys_rst = 1'b1;
  logic             locked = 1'b0, arm = 1'b0, clr_err = 1'b0;
  logic [CNT_W-1:0] line_width = 16'd8, frame_height = 16'd4;
  logic             busy, e_ll, e_fh, e_ov;
  logic [CNT_W-1:0] frame_count;

  cl_capture_sequencer_if #(.DW(DW)) cl();

  cl_capture_sequencer #(.PIX_PER_BEAT(PPB), .DW(DW), .CNT_W(CNT_W)) dut (
    .rxclk_div_1    (rxclk_div_1),
    .sys_rst        (sys_rst),
    .locked_i       (locked),
    .arm_i          (arm),
    .clr_err_i      (clr_err),
    .line_width_i   (line_width),
    .frame_height_i (frame_height),
    .cl             (cl),
    .busy_o         (busy),
    .frame_count_o  (frame_count),
    .err_line_len_o (e_ll),
    .err_frame_h_o  (e_fh),
    .err_overflow_o (e_ov)
  );

  always #5 rxclk_div_1 = ~rxclk_div_1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic [DW-1:0] got_q[$];
  int sof_n = 0, eol_n = 0, eof_n = 0;
  always @(negedge rxclk_div_1) begin
    if (!sys_rst) begin
      if (cl.wr_en) got_q.push_back(cl.pix_out);
      if (cl.sof) sof_n++;
      if (cl.eol) eol_n++;
      if (cl.eof) eof_n++;
    end
  end

  // Stimulus record: pixels of every valid beat, per line
  logic [DW-1:0] sent[8][16];
  int nsent[8];
  int bpl[8];

  // Reference state
  int m_fc = 0;
  bit m_el = 0, m_eh = 0, m_eo = 0;

  task automatic step(input int n);
    repeat (n) @(negedge rxclk_div_1);
  endtask

  task automatic drive_frame(input int nl, input int ovf_line, input int lock_line,
                             input int arm_line, input bit together);
    logic [DW-1:0] p;
    got_q.delete();
    sof_n = 0; eol_n = 0; eof_n = 0;
    // stray line outside fval, must be ignored
    cl.lval = 1; cl.dval = 1; cl.pix_in = DW'($urandom); step(2);
    cl.lval = 0; cl.dval = 0; step(2);
    cl.fval = 1; step(2);
    for (int l = 0; l < nl; l++) begin
      if (l == ovf_line)  cl.fifo_prog_full = 1;
      if (l == lock_line) locked = 0;
      if (l == arm_line)  arm = 1;
      nsent[l] = 0;
      cl.lval = 1;
      while (nsent[l] < bpl[l]) begin
        p = DW'($urandom);
        cl.pix_in = p;
        if ($urandom_range(3) == 0) cl.dval = 0;
        else begin
          cl.dval = 1;
          sent[l][nsent[l]] = p;
          nsent[l]++;
        end
        step(1);
      end
      cl.dval = 0;
      if (together && l == nl - 1) begin
        cl.lval = 0; cl.fval = 0; step(6);
      end else begin
        cl.lval = 0; step(2);
      end
    end
    if (!together) begin
      cl.fval = 0; step(6);
    end
    cl.fifo_prog_full = 0;
  endtask

  task automatic check_frame(input string nm, input int nl, input int ovf_line, input int lock_line,
                             input bit captured, input bit arm_rose);
    logic [DW-1:0] exp_q[$];
    int lines, bad;
    if (arm_rose) begin m_fc = 0; m_el = 0; m_eh = 0; m_eo = 0; end
    lines = (lock_line >= 0) ? lock_line : nl;
    if (captured) begin
      for (int l = 0; l < lines; l++) begin
        if (ovf_line < 0 || l < ovf_line)
          for (int b = 0; b < nsent[l]; b++) exp_q.push_back(sent[l][b]);
        if (nsent[l] * PPB != int'(line_width)) m_el = 1;
      end
      if (ovf_line >= 0 && ovf_line < lines) m_eo = 1;
      if (lock_line < 0) begin
        m_fc++;
        if (nl != int'(frame_height)) m_eh = 1;
      end
    end
    chk({nm, ".wr_count"}, got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({nm, ".wr_data_bad"}, bad, 0);
    chk({nm, ".sof"}, sof_n, captured ? 1 : 0);
    chk({nm, ".eol"}, eol_n, captured ? lines : 0);
    chk({nm, ".eof"}, eof_n, (captured && lock_line < 0) ? 1 : 0);
    chk({nm, ".frame_count"}, frame_count, m_fc & 32'hFFFF);
    chk({nm, ".err_line_len"}, e_ll, m_el);
    chk({nm, ".err_frame_h"}, e_fh, m_eh);
    chk({nm, ".err_overflow"}, e_ov, m_eo);
    chk({nm, ".busy"}, busy, (lock_line < 0) ? 1 : 0);
  endtask

  task automatic fill_bpl(input int n);
    for (int l = 0; l < 8; l++) bpl[l] = n;
  endtask

  task automatic pulse_clr();
    clr_err = 1; step(1); clr_err = 0;
    m_el = 0; m_eh = 0; m_eo = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cl.fval = 0; cl.lval = 0; cl.dval = 0; cl.pix_in = '0; cl.fifo_prog_full = 0;
    step(3);
    chk("rst.wr_en", cl.wr_en, 0);
    chk("rst.sof_eol_eof", {cl.sof, cl.eol, cl.eof}, 0);
    chk("rst.busy", busy, 0);
    chk("rst.frame_count", frame_count, 0);
    chk("rst.errs", {e_ll, e_fh, e_ov}, 0);
    chk("rst.pix_out", cl.pix_out, 0);
    sys_rst = 0; locked = 1; arm = 1;
    step(4);
    chk("arm.busy", busy, 1);

    // clean 4x4 frame
    fill_bpl(4);
    drive_frame(4, -1, -1, -1, 0);
    check_frame("clean", 4, -1, -1, 1, 0);
    chk("clean.writes16", got_q.size(), 16);

    // force IDLE with arm low, then raise arm mid-frame: frame must be skipped
    arm = 0; locked = 0; step(2); locked = 1; step(2);
    chk("idle.busy", busy, 0);
    drive_frame(4, -1, -1, 1, 0);
    check_frame("midarm", 4, -1, -1, 0, 1);
    drive_frame(4, -1, -1, -1, 0);
    check_frame("after_midarm", 4, -1, -1, 1, 0);

    // short line
    bpl[2] = 3;
    drive_frame(4, -1, -1, -1, 0);
    check_frame("shortline", 4, -1, -1, 1, 0);
    fill_bpl(4);
    pulse_clr();
    chk("clr.err_line_len", e_ll, 0);

    // overflow on line 2, then a normal frame
    drive_frame(4, 1, -1, -1, 0);
    check_frame("overflow", 4, 1, -1, 1, 0);
    drive_frame(4, -1, -1, -1, 0);
    check_frame("post_ovf", 4, -1, -1, 1, 0);
    chk("post_ovf.writes16", got_q.size(), 16);

    // lval and fval falling together on the last line
    drive_frame(4, -1, -1, -1, 1);
    check_frame("together", 4, -1, -1, 1, 0);

    // short frame (height error) then lock loss mid-frame
    drive_frame(3, -1, -1, -1, 0);
    check_frame("short_frame", 3, -1, -1, 1, 0);
    drive_frame(4, -1, 2, -1, 0);
    check_frame("lockloss", 4, -1, 2, 1, 0);
    locked = 1; step(4);
    m_fc = 0; m_el = 0; m_eh = 0; m_eo = 0;
    chk("relock.frame_count", frame_count, 0);
    chk("relock.busy", busy, 1);

    // randomised frames
    for (int f = 0; f < 20; f++) begin
      int nl, ovl;
      bit tog;
      nl = 3 + $urandom_range(2);
      for (int l = 0; l < 8; l++) bpl[l] = ($urandom_range(5) == 0) ? 1 + $urandom_range(5) : 4;
      ovl = ($urandom_range(4) == 0) ? $urandom_range(nl - 1) : -1;
      tog = $urandom_range(2) == 0;
      if ($urandom_range(3) == 0) pulse_clr();
      drive_frame(nl, ovl, -1, -1, tog);
      check_frame("rand", nl, ovl, -1, 1, 0);
    end

    // reset in the middle of a frame
    fill_bpl(4);
    cl.fval = 1; step(2);
    cl.lval = 1; cl.dval = 1; cl.pix_in = DW'($urandom); step(3);
    sys_rst = 1; #1;
    chk("midrst.frame_count", frame_count, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.outs", {cl.wr_en, cl.sof, cl.eol, cl.eof, e_ll, e_fh, e_ov}, 0);
    cl.lval = 0; cl.dval = 0; cl.fval = 0; step(2);
    sys_rst = 0; step(4);
    m_fc = 0; m_el = 0; m_eh = 0; m_eo = 0;
    drive_frame(4, -1, -1, -1, 0);
    check_frame("after_rst", 4, -1, -1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
